axis_mm2s_cmd_sched: RTL and testbench

//  Multi-channel MM2S command scheduler for the AXI DataMover read path, on the axi_aclk domain.

---
 rtl/axis_mm2s_cmd_sched.sv | 159 +++++++++++++++
 tb/tb_axis_mm2s_cmd_sched.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_mm2s_cmd_sched.sv
// axis_mm2s_cmd_sched: round-robin DataMover MM2S command scheduler with per-channel tag tracking.
// Optional MM2S_STS_ERR_HALT_EN: an error status drains its channel and blocks restart until reset.
module axis_mm2s_cmd_sched #(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = 32,
    parameter int PKT_BYTES = 4096,
    parameter int MAX_OUTST = 4
) (
    input  logic                     axi_aclk,
    input  logic                     axi_rstb,
    output logic [ADDR_W+39:0]       cmd_tdata,
    output logic                     cmd_tvalid,
    input  logic                     cmd_tready,
    input  logic [7:0]               sts_tdata,
    input  logic                     sts_tvalid,
    output logic                     sts_tready,
    input  logic [NUM_CH-1:0]        start,
    input  logic [NUM_CH-1:0]        stop,
    input  logic [NUM_CH-1:0]        loop_en,
    input  logic [NUM_CH*ADDR_W-1:0] base_addr,
    input  logic [NUM_CH*32-1:0]     cap_size,
    output logic [NUM_CH-1:0]        ch_busy,
    output logic [NUM_CH*ADDR_W-1:0] current_addr,
    output logic [NUM_CH*8-1:0]      run_cycles,
    output logic [7:0]               last_status,
    output logic                     err
);
    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam logic [31:0] PKT = 32'(PKT_BYTES);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t            st_q    [NUM_CH];
    state_t            st_d    [NUM_CH];
    logic [ADDR_W-1:0] base_q  [NUM_CH];
    logic [31:0]       size_q  [NUM_CH];
    logic [31:0]       off_q   [NUM_CH];
    logic [3:0]        outst_q [NUM_CH];
    logic [ADDR_W-1:0] cur_q   [NUM_CH];
    logic [7:0]        runc_q  [NUM_CH];
    logic [CW-1:0]     last_ch, pick;
    logic [4:0]        idx;
    logic              found, slot, do_load, accept, chunk_last, sts_err, stray;
    logic [31:0]       rem;
    logic [22:0]       btt;
    logic [ADDR_W-1:0] saddr;
    logic [3:0]        cmd_tag;
    logic [NUM_CH-1:0] pend, elig, inc, dec, sts_hit, halt, blocked;

    assign sts_tready = 1'b1;
    assign cmd_tag    = cmd_tdata[ADDR_W+35:ADDR_W+32];
    assign accept     = cmd_tvalid & cmd_tready;
    assign slot       = ~cmd_tvalid | cmd_tready;
    assign sts_err    = |sts_tdata[6:4];

    // the command sitting in the output register counts against its channel's outstanding limit
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            pend[c]    = cmd_tvalid && cmd_tag == 4'(c);
            elig[c]    = st_q[c] == ACTIVE && !stop[c] && 5'(outst_q[c]) + 5'(pend[c]) < 5'(MAX_OUTST);
            sts_hit[c] = sts_tvalid && sts_tdata[3:0] == 4'(c);
            inc[c]     = accept && pend[c];
            dec[c]     = sts_hit[c] && outst_q[c] != 4'd0;
        end
        stray = sts_tvalid && dec == '0;
    end

    always_comb begin
        found = 1'b0;
        pick  = last_ch;
        idx   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = 5'(last_ch) + 5'(i);
            idx = idx >= 5'(NUM_CH) ? idx - 5'(NUM_CH) : idx;
            if (!found && elig[CW'(idx)]) begin
                found = 1'b1;
                pick  = CW'(idx);
            end
        end
    end

    assign rem        = size_q[pick] - off_q[pick];
    assign chunk_last = rem <= PKT;
    assign btt        = chunk_last ? rem[22:0] : PKT[22:0];
    assign saddr      = base_q[pick] + ADDR_W'(off_q[pick]);
    assign do_load    = slot && found;

`ifdef MM2S_STS_ERR_HALT_EN
    logic [NUM_CH-1:0] halt_q;
    assign halt    = sts_err ? sts_hit : '0;
    assign blocked = halt_q;
    always_ff @(posedge axi_aclk) halt_q <= !axi_rstb ? '0 : halt_q | halt;
`else
    assign halt    = '0;
    assign blocked = '0;
`endif

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            st_d[c] = st_q[c];
            case (st_q[c])
                IDLE:    if (start[c] && cap_size[c*32 +: 32] != 32'd0 && !blocked[c]) st_d[c] = ACTIVE;
                ACTIVE:  if (stop[c] || halt[c] || (do_load && pick == CW'(c) && chunk_last && !loop_en[c])) st_d[c] = DRAIN;
                DRAIN:   if (outst_q[c] == 4'd0 && !pend[c]) st_d[c] = IDLE;
                default: st_d[c] = IDLE;
            endcase
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_rstb) begin
            cmd_tvalid  <= 1'b0;
            cmd_tdata   <= '0;
            last_ch     <= CW'(NUM_CH - 1);
            last_status <= '0;
            err         <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                st_q[c]    <= IDLE;
                base_q[c]  <= '0;
                size_q[c]  <= '0;
                off_q[c]   <= '0;
                outst_q[c] <= '0;
                cur_q[c]   <= '0;
                runc_q[c]  <= '0;
            end
        end else begin
            if (do_load) begin
                cmd_tdata <= {4'd0, 4'(pick), saddr, 1'b0, chunk_last, 6'd0, 1'b1, btt};
                last_ch   <= pick;
            end
            cmd_tvalid <= do_load || (cmd_tvalid && !cmd_tready);
            if (sts_tvalid) last_status <= sts_tdata;
            err <= err || stray || (sts_tvalid && sts_err);
            for (int c = 0; c < NUM_CH; c++) begin
                st_q[c] <= st_d[c];
                if (st_q[c] == IDLE && st_d[c] == ACTIVE) begin
                    base_q[c] <= base_addr[c*ADDR_W +: ADDR_W];
                    size_q[c] <= cap_size[c*32 +: 32];
                    off_q[c]  <= '0;
                    cur_q[c]  <= '0;
                    runc_q[c] <= '0;
                end else if (do_load && pick == CW'(c)) begin
                    off_q[c] <= chunk_last ? '0 : off_q[c] + PKT;
                    if (chunk_last) runc_q[c] <= runc_q[c] + 8'd1;
                end
                if (inc[c]) cur_q[c] <= cmd_tdata[ADDR_W+31:32];
                outst_q[c] <= outst_q[c] + 4'(inc[c]) - 4'(dec[c]);
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            ch_busy[c]                     = st_q[c] != IDLE;
            current_addr[c*ADDR_W +: ADDR_W] = cur_q[c];
            run_cycles[c*8 +: 8]           = runc_q[c];
        end
    end
endmodule

// File: tb/tb_axis_mm2s_cmd_sched.sv
// tb_axis_mm2s_cmd_sched: directed scenarios plus randomized traffic against a chunk-list reference model.
module tb_axis_mm2s_cmd_sched;
    localparam int NUM_CH = 2;
    localparam int ADDR_W = 32;
    localparam int PKT    = 4096;
    localparam int MAXO   = 4;
    localparam int CW     = ADDR_W + 40;

    logic                     clk = 1'b0;
    logic                     rstb = 1'b0;
    logic [CW-1:0]            cmd_tdata;
    logic                     cmd_tvalid;
    logic                     cmd_tready = 1'b0;
    logic [7:0]               sts_tdata = '0;
    logic                     sts_tvalid = 1'b0;
    logic                     sts_tready;
    logic [NUM_CH-1:0]        start = '0, stop = '0, loop_en = '0, ch_busy;
    logic [NUM_CH*ADDR_W-1:0] base_addr = '0, current_addr;
    logic [NUM_CH*32-1:0]     cap_size = '0;
    logic [NUM_CH*8-1:0]      run_cycles;
    logic [7:0]               last_status;
    logic                     err;

    always #5 clk = ~clk;

    axis_mm2s_cmd_sched #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .PKT_BYTES(PKT), .MAX_OUTST(MAXO)) dut (
        .axi_aclk(clk), .axi_rstb(rstb),
        .cmd_tdata(cmd_tdata), .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready),
        .sts_tdata(sts_tdata), .sts_tvalid(sts_tvalid), .sts_tready(sts_tready),
        .start(start), .stop(stop), .loop_en(loop_en),
        .base_addr(base_addr), .cap_size(cap_size),
        .ch_busy(ch_busy), .current_addr(current_addr), .run_cycles(run_cycles),
        .last_status(last_status), .err(err)
    );

    int n_cmp = 0, n_bad = 0;

    // reference model: per channel, the remaining chunk list is implied by size and offset
    logic [ADDR_W-1:0] m_base [NUM_CH];
    logic [31:0]       m_size [NUM_CH];
    logic [31:0]       m_off  [NUM_CH];
    logic [ADDR_W-1:0] m_cur  [NUM_CH];
    int                m_runc [NUM_CH];
    int                m_outst[NUM_CH];
    bit                m_live [NUM_CH];
    logic              m_err;
    logic [7:0]        m_last;
    int                q_tag[$];
    int                acc_tags[$];
    bit                auto_sts = 0;
    int                sts_pct = 0;
    int                rdy_pct = -1;
    bit                prev_hold = 0;
    logic [CW-1:0]     prev_d;

    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_base[c] = '0; m_size[c] = '0; m_off[c] = '0; m_cur[c] = '0;
            m_runc[c] = 0; m_outst[c] = 0; m_live[c] = 0;
        end
        m_err = 1'b0;
        m_last = '0;
        q_tag.delete();
        prev_hold = 0;
    endfunction

    task automatic model_accept(logic [CW-1:0] d);
        int ch;
        logic [31:0] rem, btt;
        logic eof;
        ch = int'(d[ADDR_W+35:ADDR_W+32]);
        check("tag_range", ch < NUM_CH, 1);
        if (ch >= NUM_CH) return;
        rem = m_size[ch] - m_off[ch];
        eof = rem <= PKT;
        btt = eof ? rem : PKT;
        check("cmd_expected", m_live[ch], 1);
        check("outst_limit", m_outst[ch] < MAXO, 1);
        check("btt", d[22:0], btt[22:0]);
        check("saddr", d[ADDR_W+31:32], m_base[ch] + m_off[ch]);
        check("eof", d[30], eof);
        check("fixed_bits", {d[CW-1:CW-4], d[31], d[29:23]}, 12'h001);
        m_cur[ch] = m_base[ch] + m_off[ch];
        m_outst[ch]++;
        acc_tags.push_back(ch);
        q_tag.push_back(ch);
        if (eof) begin
            m_runc[ch]++;
            m_off[ch] = '0;
            if (!loop_en[ch]) m_live[ch] = 0;
        end else m_off[ch] = m_off[ch] + PKT;
    endtask

    function automatic void model_status(logic [7:0] s);
        int t;
        t = int'(s[3:0]);
        m_last = s;
        if (t < NUM_CH && m_outst[t] > 0) m_outst[t]--;
        else m_err = 1'b1;
        if (s[6:4] != 3'd0) m_err = 1'b1;
    endfunction

    task automatic cyc();
        logic [CW-1:0] d;
        d = cmd_tdata;
        if (auto_sts && !sts_tvalid && q_tag.size() > 0 && $urandom_range(99) < sts_pct) begin
            int k;
            k = $urandom_range(q_tag.size() - 1);
            sts_tdata = 8'h80 | 8'(q_tag[k]);
            q_tag.delete(k);
            sts_tvalid = 1'b1;
        end
        if (prev_hold) begin
            check("hold_valid", cmd_tvalid, 1);
            check("hold_stable", d, prev_d);
        end
        prev_hold = cmd_tvalid && !cmd_tready;
        prev_d = d;
        if (cmd_tvalid && cmd_tready) model_accept(d);
        if (sts_tvalid) model_status(sts_tdata);
        @(posedge clk);
        #1;
        start = '0;
        stop = '0;
        sts_tvalid = 1'b0;
        if (rdy_pct >= 0) cmd_tready = $urandom_range(99) < rdy_pct;
        @(negedge clk);
        for (int c = 0; c < NUM_CH; c++) check("current_addr", current_addr[c*ADDR_W +: ADDR_W], m_cur[c]);
        check("last_status", last_status, m_last);
        check("err", err, m_err);
    endtask

    task automatic send_sts(logic [7:0] s);
        sts_tdata = s;
        sts_tvalid = 1'b1;
        foreach (q_tag[i]) if (q_tag[i] == int'(s[3:0])) begin
            q_tag.delete(i);
            break;
        end
    endtask

    task automatic start_ch(int ch, logic [ADDR_W-1:0] base, logic [31:0] size, bit lp, bit take);
        base_addr[ch*ADDR_W +: ADDR_W] = base;
        cap_size[ch*32 +: 32] = size;
        loop_en[ch] = lp;
        start[ch] = 1'b1;
        if (take && size != 0) begin
            m_base[ch] = base; m_size[ch] = size; m_off[ch] = '0;
            m_cur[ch] = '0; m_runc[ch] = 0; m_live[ch] = 1;
        end
    endtask

    task automatic reset_dut(int edges);
        rstb = 1'b0;
        start = '0; stop = '0; sts_tvalid = 1'b0; cmd_tready = 1'b0;
        rdy_pct = -1; auto_sts = 0;
        repeat (edges) @(posedge clk);
        #1;
        @(negedge clk);
        model_reset();
        check("rst_cmd_tvalid", cmd_tvalid, 0);
        check("rst_cmd_tdata", cmd_tdata, 0);
        check("rst_sts_tready", sts_tready, 1);
        check("rst_ch_busy", ch_busy, 0);
        check("rst_run_cycles", run_cycles, 0);
        check("rst_current_addr", current_addr, 0);
        check("rst_last_status", last_status, 0);
        check("rst_err", err, 0);
        rstb = 1'b1;
    endtask

    task automatic drain(int budget);
        int i;
        auto_sts = 1; sts_pct = 100; rdy_pct = 100;
        i = 0;
        while (i < budget && (ch_busy != '0 || q_tag.size() != 0)) begin
            cyc();
            i++;
        end
        check("drain_idle", ch_busy, 0);
        for (int c = 0; c < NUM_CH; c++) check("run_cycles", run_cycles[c*8 +: 8], 8'(m_runc[c]));
    endtask

    initial begin
        int n;
        reset_dut(3);

        // one-shot pass of three full chunks, then status returns the channel to idle
        cmd_tready = 1'b1;
        acc_tags.delete();
        start_ch(0, 32'h1000_0000, 32'h3000, 0, 1);
        cyc();
        check("t1_latency_valid0", cmd_tvalid, 0);
        check("t1_busy", ch_busy[0], 1);
        cyc();
        check("t1_latency_valid1", cmd_tvalid, 1);
        repeat (10) cyc();
        check("t1_cmd_count", acc_tags.size(), 3);
        check("t1_run_cycles", run_cycles[7:0], 1);
        check("t1_busy_wait", ch_busy[0], 1);
        repeat (3) begin send_sts(8'h80); cyc(); end
        cyc(); cyc();
        check("t1_idle", ch_busy, 0);

        // zero-size start is ignored
        start_ch(1, 32'h5000_0000, 32'h0, 0, 1);
        cyc(); cyc();
        check("size0_ignored", ch_busy[1], 0);

        // looping partial pass, run count wraps through 255
        start_ch(0, 32'h2000_0000, 32'h2800, 1, 1);
        auto_sts = 1; sts_pct = 100; rdy_pct = 100;
        n = 0;
        while (m_runc[0] < 257 && n < 20000) begin cyc(); n++; end
        check("t2_pass_budget", m_runc[0] >= 257, 1);
        start_ch(0, 32'h7000_0000, 32'h100, 0, 0);
        cyc();
        check("start_while_busy_ignored", ch_busy[0], 1);
        stop[0] = 1'b1;
        drain(200);

        // round robin and outstanding limit
        reset_dut(2);
        cmd_tready = 1'b1;
        acc_tags.delete();
        start_ch(0, 32'h0001_0000, 32'h10_0000, 0, 1);
        start_ch(1, 32'h0800_0000, 32'h10_0000, 0, 1);
        repeat (20) cyc();
        check("t3_stall_count", acc_tags.size(), 2 * MAXO);
        foreach (acc_tags[i]) check("t3_alternate", acc_tags[i], i % 2);
        send_sts(8'h81);
        repeat (10) cyc();
        check("t3_one_more", acc_tags.size(), 2 * MAXO + 1);
        if (acc_tags.size() > 2 * MAXO) check("t3_one_more_tag", acc_tags[2 * MAXO], 1);
        stop = '1;
        drain(200);

        // held command stays stable and is delivered after stop
        rdy_pct = -1; auto_sts = 0;
        cmd_tready = 1'b0;
        acc_tags.delete();
        start_ch(0, 32'hFFFF_F000, 32'h10000, 0, 1);
        cyc(); cyc();
        check("t4_pending", cmd_tvalid, 1);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) stop[0] = 1'b1;
            cyc();
        end
        cmd_tready = 1'b1;
        repeat (5) cyc();
        check("t4_delivered_once", acc_tags.size(), 1);
        check("t4_busy_outst", ch_busy[0], 1);
        send_sts(8'h80);
        cyc(); cyc();
        check("t4_idle", ch_busy[0], 0);

        // randomized traffic on both channels
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < NUM_CH; c++)
                start_ch(c, $urandom, $urandom_range(1, 5 * PKT), $urandom_range(1), 1);
            auto_sts = 1; sts_pct = 40; rdy_pct = 70;
            repeat (300) cyc();
            stop = '1;
            drain(500);
        end

        // error status
        rdy_pct = -1; auto_sts = 0;
        cmd_tready = 1'b1;
        acc_tags.delete();
        start_ch(1, 32'h3000_0000, 32'h10_0000, 0, 1);
        repeat (8) cyc();
        check("t5_stalled", acc_tags.size(), MAXO);
        send_sts(8'h41);
        cyc();
        check("t5_err", err, 1);
        check("t5_last_status", last_status, 8'h41);
        repeat (8) cyc();
`ifdef MM2S_STS_ERR_HALT_EN
        check("t5_halted", acc_tags.size(), MAXO);
`else
        check("t5_continues", acc_tags.size(), MAXO + 1);
`endif
        stop[1] = 1'b1;
        drain(200);
`ifdef MM2S_STS_ERR_HALT_EN
        start_ch(1, 32'h3000_0000, 32'h1000, 0, 0);
        cyc(); cyc();
        check("t5_restart_blocked", ch_busy[1], 0);
`endif

        // reset mid-transfer, then a stale status
        reset_dut(2);
        cmd_tready = 1'b1;
        start_ch(0, 32'h4000_0000, 32'h10_0000, 0, 1);
        repeat (5) cyc();
        reset_dut(1);
        cyc();
        send_sts(8'h80);
        cyc();
        check("t6_stale_err", err, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
